// File: rtl/serial_adder_sub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// The master drives the request and operands. The slave returns status and the result.
interface serial_adder_sub_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_adder_sub.sv
// Bit-serial adder/subtractor built from one full-adder cell and a carry flip-flop.
// It processes one operand bit per clock, LSB first, and commits sum, carry-out
// and signed overflow together with a one-cycle done pulse.
module serial_adder_sub #(
    parameter int WIDTH = 8,
    parameter int CW    = 6
) (
    input  logic               clk,
    input  logic               reset,
    serial_adder_sub_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;        // operand A, shifted right each RUN cycle
    logic [WIDTH-1:0] sb;        // operand B (pre-inverted for subtract)
    logic [WIDTH-1:0] ps;        // partial sum, filled from the MSB end
    logic             c;         // running carry
    logic [CW-1:0]    cnt;       // bit index currently being added

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             ovf_q;
    logic             busy_q;
    logic             done_q;

    logic             s;
    logic             c_next;
    logic [WIDTH-1:0] ps_next;
    logic             last_bit;

    // The single full-adder cell plus the next value of the partial-sum shifter
    always_comb begin
        // NOTE: ps_next gets a complete default before its MSB is overridden,
        // so every bit is assigned on every pass and no latch is inferred.
        ps_next          = ps >> 1;
        s                = sa[0] ^ sb[0] ^ c;
        c_next           = (sa[0] & sb[0]) | (sa[0] & c) | (sb[0] & c);
        ps_next[WIDTH-1] = s;
        last_bit         = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM and datapath registers, all with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: every register here uses non-blocking assignments, so all of
        // them sample the pre-edge values of one another (shifters, carry, counter).
        if (reset) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            ps     <= '0;
            c      <= 1'b0;
            cnt    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.sub ? ~bus.b : bus.b;
                        c      <= bus.sub ? 1'b1 : bus.cin;
                        ps     <= '0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    sa  <= sa >> 1;
                    sb  <= sb >> 1;
                    c   <= c_next;
                    ps  <= ps_next;
                    cnt <= cnt + CW'(1);
                    if (last_bit) begin
                        // The current carry is the carry into the MSB; commit all results at once
                        sum_q  <= ps_next;
                        cout_q <= c_next;
                        ovf_q  <= c ^ c_next;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    busy_q <= 1'b0;
                    done_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;
    assign bus.ovf  = ovf_q;

endmodule
